// File: rtl/d_fork_v.sv
`default_nettype none
// ============================================================================
// Module   : d_fork_v
// Brief    : Eager broadcast fork. Holds one token in a payload register and
//            offers it to the branches selected by fork_mask. Each branch
//            handshakes once per token. The next token is accepted only when
//            every selected branch has taken the current one.
// Options  : FORK_TOKEN_COUNT_EN adds the tokens_out completed-token counter.
// Revision : 1.0 - initial release
// ============================================================================
module d_fork_v #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   din_v,
  output logic                   din_r,
  input  logic [NUM_OUTPUTS-1:0] fork_mask,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [NUM_OUTPUTS-1:0] dout_v,
  input  logic [NUM_OUTPUTS-1:0] dout_r
`ifdef FORK_TOKEN_COUNT_EN
  ,
  output logic [15:0]            tokens_out
`endif
);

  logic [NUM_OUTPUTS-1:0] r_pend;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [NUM_OUTPUTS-1:0] w_remaining;
  logic                   w_accept;

  // Branches still owed the current token after this cycle's handshakes.
  // din_r depends combinationally on dout_r, so the slot refills with no bubble.
  always_comb begin
    w_remaining = r_pend & ~dout_r;
    din_r       = reset & (w_remaining == '0);
    w_accept    = din_v & din_r;
  end

  // Load the token and branch set on accept, otherwise retire completed branches.
  // A load overrides every bit, because remaining == 0 implies the old token is done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_pend <= fork_mask;
      r_data <= din;
    end else begin
      r_pend <= w_remaining;
    end
  end

  assign dout   = r_data;
  assign dout_v = r_pend;

`ifdef FORK_TOKEN_COUNT_EN
  logic [15:0] r_count;

  // Count tokens whose last outstanding branches complete in this cycle.
  // A token with a zero mask never pends, so it is never counted. The count saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if ((r_pend != '0) && (w_remaining == '0) && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign tokens_out = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_fork_v.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_fork_v
// Brief    : Directed self-checking bench for d_fork_v.
// Options  : FORK_TOKEN_COUNT_EN enables the tokens_out checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_fork_v;

  logic        clock;
  logic        reset;
  logic [31:0] din;
  logic        din_v;
  logic        din_r;
  logic [3:0]  fork_mask;
  logic [31:0] dout;
  logic [3:0]  dout_v;
  logic [3:0]  dout_r;
`ifdef FORK_TOKEN_COUNT_EN
  logic [15:0] tokens_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  d_fork_v #(.DATA_WIDTH(32), .NUM_OUTPUTS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .din_v     (din_v),
    .din_r     (din_r),
    .fork_mask (fork_mask),
    .dout      (dout),
    .dout_v    (dout_v),
    .dout_r    (dout_r)
`ifdef FORK_TOKEN_COUNT_EN
    ,
    .tokens_out(tokens_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    din       = 32'hDEAD_BEEF;
    din_v     = 1'b1;
    fork_mask = 4'b1111;
    dout_r    = 4'b0000;

    // Reset held with a valid token presented upstream.
    repeat (3) tick();
    check("rst_dout",   dout,          32'h0);
    check("rst_dout_v", 32'(dout_v),   32'h0);
    check("rst_din_r",  32'(din_r),    32'h0);

    reset     = 1'b1;
    din       = 32'hA5A5_0001;
    fork_mask = 4'b1111;
    #1;
    check("idle_din_r", 32'(din_r), 32'h1);
    tick();
    check("first_dout",   dout,        32'hA5A5_0001);
    check("first_dout_v", 32'(dout_v), 32'hF);

    // Full throughput: tokens 1..8 with every branch ready.
    dout_r = 4'b1111;
    din    = 32'd1;
    #1;
    check("tp_din_r_0", 32'(din_r), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("tp_dout_%0d", k),   dout,        32'(k));
      check($sformatf("tp_dout_v_%0d", k), 32'(dout_v), 32'hF);
      din = 32'(k + 1);
      if (k == 8) din_v = 1'b0;
      #1;
      check($sformatf("tp_din_r_%0d", k), 32'(din_r), 32'h1);
    end
    tick();
    check("tp_drain_v", 32'(dout_v), 32'h0);
`ifdef FORK_TOKEN_COUNT_EN
    check("tp_count", 32'(tokens_out), 32'd9);
`endif

    // Staggered ready on mask 1011 with token 0x55.
    dout_r    = 4'b0000;
    din       = 32'h55;
    fork_mask = 4'b1011;
    din_v     = 1'b1;
    tick();
    check("st_dout",  dout,        32'h55);
    check("st_v0",    32'(dout_v), 32'hB);
    din       = 32'h66;
    fork_mask = 4'b1111;
    dout_r    = 4'b0001;          // cycle 1
    #1;
    check("st_din_r1", 32'(din_r), 32'h0);
    tick();
    check("st_v1", 32'(dout_v), 32'hA);
    dout_r = 4'b0000;             // cycle 2
    tick();
    check("st_v2", 32'(dout_v), 32'hA);
    dout_r = 4'b0011;             // cycle 3, branch 0 ready again but already served
    #1;
    check("st_din_r3", 32'(din_r), 32'h0);
    tick();
    check("st_v3",   32'(dout_v), 32'h8);
    check("st_hold", dout,        32'h55);
    dout_r = 4'b0000;             // cycle 4
    tick();
    check("st_v4", 32'(dout_v), 32'h8);
    // Cycle 5: last branch completes while a new token waits -> same-cycle refill.
    dout_r    = 4'b1000;
    din       = 32'h77;
    fork_mask = 4'b0100;
    #1;
    check("st_din_r5", 32'(din_r), 32'h1);
    tick();
    check("rf_dout",   dout,        32'h77);
    check("rf_dout_v", 32'(dout_v), 32'h4);
    din_v  = 1'b0;
    dout_r = 4'b0100;
    #1;
    check("rf_din_r", 32'(din_r), 32'h1);
    tick();
    check("rf_drain", 32'(dout_v), 32'h0);
`ifdef FORK_TOKEN_COUNT_EN
    check("rf_count", 32'(tokens_out), 32'd11);
`endif

    // Mask zero: token consumed and dropped.
    dout_r    = 4'b0000;
    din       = 32'h99;
    fork_mask = 4'b0000;
    din_v     = 1'b1;
    #1;
    check("mz_din_r_a", 32'(din_r), 32'h1);
    tick();
    check("mz_dout_v",  32'(dout_v), 32'h0);
    check("mz_dout",    dout,        32'h99);
    check("mz_din_r_b", 32'(din_r),  32'h1);
`ifdef FORK_TOKEN_COUNT_EN
    tick();
    check("mz_count", 32'(tokens_out), 32'd11);
`endif

    // Mask change while pending has no effect.
    din       = 32'hAB;
    fork_mask = 4'b0110;
    din_v     = 1'b1;
    tick();
    check("mc_v0", 32'(dout_v), 32'h6);
    din_v     = 1'b0;
    fork_mask = 4'b1111;
    tick();
    check("mc_v1", 32'(dout_v), 32'h6);
    dout_r = 4'b0100;
    tick();
    check("mc_v2", 32'(dout_v), 32'h2);
    dout_r = 4'b0000;

    // Asynchronous reset mid-token: outputs clear without a clock edge.
    reset = 1'b0;
    #1;
    check("ar_dout_v", 32'(dout_v), 32'h0);
    check("ar_dout",   dout,        32'h0);
    check("ar_din_r",  32'(din_r),  32'h0);
`ifdef FORK_TOKEN_COUNT_EN
    check("ar_count",  32'(tokens_out), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
